// File: rtl/uart_rx_check.sv
// Checks that received UART bytes form a modulo-256 incrementing sequence.
// Optional: define UART_RX_CHECK_RELOCK_EN to drop lock and reacquire on a sequence error.
module uart_rx_check #(
  parameter int unsigned TIMEOUT  = 100000,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             cnt_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             timeout_pulse,
  output logic             timeout_seen,
  output logic [7:0]       last_data,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned      WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [7:0]       LOCK_RUN = 8'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [7:0]        exp_byte, exp_byte_n;
  logic [7:0]        run, run_n;
  logic [WD_W-1:0]   wdog, wdog_n;
  logic              locked_n, err_pulse_n, timeout_pulse_n, timeout_seen_n;
  logic [7:0]        last_data_n;
  logic [CNT_W-1:0]  good_cnt_n, err_cnt_n;
  logic              match;

  assign match = (rx_data == exp_byte);

  // State and statistics registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= HUNT;
      exp_byte      <= 8'd0;
      run           <= 8'd0;
      wdog          <= '0;
      locked        <= 1'b0;
      err_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;
      timeout_seen  <= 1'b0;
      last_data     <= 8'd0;
      good_cnt      <= '0;
      err_cnt       <= '0;
    end else begin
      state         <= state_n;
      exp_byte      <= exp_byte_n;
      run           <= run_n;
      wdog          <= wdog_n;
      locked        <= locked_n;
      err_pulse     <= err_pulse_n;
      timeout_pulse <= timeout_pulse_n;
      timeout_seen  <= timeout_seen_n;
      last_data     <= last_data_n;
      good_cnt      <= good_cnt_n;
      err_cnt       <= err_cnt_n;
    end
  end

  // Next-state, sequence check, watchdog and statistics
  always_comb begin
    state_n         = state;
    exp_byte_n      = exp_byte;
    run_n           = run;
    wdog_n          = wdog;
    err_pulse_n     = 1'b0;
    timeout_pulse_n = 1'b0;
    timeout_seen_n  = timeout_seen;
    last_data_n     = last_data;
    good_cnt_n      = good_cnt;
    err_cnt_n       = err_cnt;

    if (rx_valid) begin
      // A byte always re-arms the watchdog, so it wins over a same-cycle expiry
      exp_byte_n  = rx_data + 8'd1;
      last_data_n = rx_data;
      wdog_n      = '0;
      case (state)
        HUNT: begin
          run_n = 8'd1;
          if (LOCK_CNT == 1) state_n = LOCK;
          else               state_n = ACQ;
        end
        ACQ: begin
          if (match) begin
            run_n = run + 8'd1;
            if (run + 8'd1 == LOCK_RUN) state_n = LOCK;
          end else begin
            run_n = 8'd1;
          end
        end
        LOCK: begin
          if (match) begin
            if (good_cnt != CNT_MAX) good_cnt_n = good_cnt + CNT_W'(1);
          end else begin
            err_pulse_n = 1'b1;
            if (err_cnt != CNT_MAX) err_cnt_n = err_cnt + CNT_W'(1);
`ifdef UART_RX_CHECK_RELOCK_EN
            run_n = 8'd1;
            if (LOCK_CNT == 1) state_n = LOCK;
            else               state_n = ACQ;
`endif
          end
        end
        default: state_n = HUNT;
      endcase
    end else if (state == HUNT) begin
      wdog_n = '0;
    end else if (wdog == WD_LAST) begin
      timeout_pulse_n = 1'b1;
      timeout_seen_n  = 1'b1;
      state_n         = HUNT;
      run_n           = 8'd0;
      wdog_n          = '0;
    end else begin
      wdog_n = wdog + WD_W'(1);
    end

    // Clear beats any same-cycle increment or timeout flag; pulses are unaffected
    if (cnt_clr) begin
      good_cnt_n     = '0;
      err_cnt_n      = '0;
      timeout_seen_n = 1'b0;
    end

    locked_n = (state_n == LOCK);
  end

endmodule

// File: tb/tb_uart_rx_check.sv
// Bench for uart_rx_check: directed vector table, corner-case sequences and a
// randomized run checked cycle by cycle against a behavioural model.
module tb_uart_rx_check;

  localparam int unsigned TIMEOUT  = 64;
  localparam int unsigned LOCK_CNT = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int          CMAX     = (1 << CNT_W) - 1;
`ifdef UART_RX_CHECK_RELOCK_EN
  localparam bit RELOCK = 1'b1;
`else
  localparam bit RELOCK = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             cnt_clr;
  logic             locked;
  logic             err_pulse;
  logic             timeout_pulse;
  logic             timeout_seen;
  logic [7:0]       last_data;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] err_cnt;

  uart_rx_check #(
    .TIMEOUT (TIMEOUT),
    .LOCK_CNT(LOCK_CNT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .cnt_clr      (cnt_clr),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .timeout_pulse(timeout_pulse),
    .timeout_seen (timeout_seen),
    .last_data    (last_data),
    .good_cnt     (good_cnt),
    .err_cnt      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // Behavioural model: mode 0 = hunting, 1 = acquiring, 2 = locked
  int         m_mode, m_run, m_idle, m_good, m_errc;
  bit         m_errp, m_top, m_seen;
  logic [7:0] m_exp, m_last;

  function automatic void model_reset();
    m_mode = 0; m_run = 0; m_idle = 0; m_good = 0; m_errc = 0;
    m_errp = 1'b0; m_top = 1'b0; m_seen = 1'b0;
    m_exp = 8'd0; m_last = 8'd0;
  endfunction

  function automatic void model_step(bit v, logic [7:0] d, bit clr, bit rst);
    bit hit;
    m_errp = 1'b0;
    m_top  = 1'b0;
    if (!rst) begin
      model_reset();
      return;
    end
    if (v) begin
      hit = (m_mode != 0) && (d == m_exp);
      if (m_mode == 2) begin
        if (hit) m_good = (m_good == CMAX) ? CMAX : m_good + 1;
        else begin
          m_errp = 1'b1;
          m_errc = (m_errc == CMAX) ? CMAX : m_errc + 1;
          if (RELOCK) begin
            m_run  = 1;
            m_mode = (m_run >= int'(LOCK_CNT)) ? 2 : 1;
          end
        end
      end else begin
        m_run  = (m_mode == 1 && hit) ? m_run + 1 : 1;
        m_mode = (m_run >= int'(LOCK_CNT)) ? 2 : 1;
      end
      m_exp  = d + 8'd1;
      m_last = d;
      m_idle = 0;
    end else if (m_mode == 0) begin
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle == int'(TIMEOUT)) begin
        m_mode = 0; m_run = 0; m_idle = 0;
        m_top = 1'b1; m_seen = 1'b1;
      end
    end
    if (clr) begin
      m_good = 0; m_errc = 0; m_seen = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cycle);
    end
  endtask

  task automatic check_model();
    logic [19:0] act, expv;
    act  = {locked, err_pulse, timeout_pulse, timeout_seen, last_data, good_cnt, err_cnt};
    expv = {(m_mode == 2), m_errp, m_top, m_seen, m_last, CNT_W'(m_good), CNT_W'(m_errc)};
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL model cycle %0d: got lk=%0b ep=%0b tp=%0b ts=%0b last=%02h good=%0d err=%0d expected lk=%0b ep=%0b tp=%0b ts=%0b last=%02h good=%0d err=%0d",
               cycle, act[19], act[18], act[17], act[16], act[15:8], act[7:4], act[3:0],
               expv[19], expv[18], expv[17], expv[16], expv[15:8], expv[7:4], expv[3:0]);
    end
  endtask

  // One clock: drive, advance the model on the edge, then compare 1 time unit later
  task automatic cyc(input bit v, input logic [7:0] d, input bit clr);
    rx_valid = v;
    rx_data  = d;
    cnt_clr  = clr;
    @(posedge clk);
    model_step(v, d, clr, rst_n);
    cycle++;
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
  endtask

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         lk;
    bit         ep;
    int         good;
    int         errc;
    logic [7:0] last;
  } vec_t;

  function automatic vec_t mk(bit v, logic [7:0] d, bit lk, bit ep, int good, int errc,
                              logic [7:0] last);
    vec_t r;
    r.v = v; r.d = d; r.lk = lk; r.ep = ep; r.good = good; r.errc = errc; r.last = last;
    return r;
  endfunction

  vec_t vecs[14];

  initial begin
    int np, e, m, ge;
    logic [7:0] b;

    vecs[0]  = mk(1'b1, 8'hFA, 1'b0, 1'b0, 0, 0, 8'hFA);
    vecs[1]  = mk(1'b1, 8'hFB, 1'b0, 1'b0, 0, 0, 8'hFB);
    vecs[2]  = mk(1'b1, 8'hFC, 1'b0, 1'b0, 0, 0, 8'hFC);
    vecs[3]  = mk(1'b1, 8'hFD, 1'b1, 1'b0, 0, 0, 8'hFD);
    vecs[4]  = mk(1'b0, 8'h77, 1'b1, 1'b0, 0, 0, 8'hFD);
    vecs[5]  = mk(1'b1, 8'hFE, 1'b1, 1'b0, 1, 0, 8'hFE);
    vecs[6]  = mk(1'b1, 8'hFF, 1'b1, 1'b0, 2, 0, 8'hFF);
    vecs[7]  = mk(1'b1, 8'h00, 1'b1, 1'b0, 3, 0, 8'h00);
    vecs[8]  = mk(1'b1, 8'h01, 1'b1, 1'b0, 4, 0, 8'h01);
    vecs[9]  = mk(1'b1, 8'h30, !RELOCK, 1'b1, 4, 1, 8'h30);
    vecs[10] = mk(1'b1, 8'h31, !RELOCK, 1'b0, RELOCK ? 4 : 5, 1, 8'h31);
    vecs[11] = mk(1'b1, 8'h32, !RELOCK, 1'b0, RELOCK ? 4 : 6, 1, 8'h32);
    vecs[12] = mk(1'b1, 8'h33, 1'b1, 1'b0, RELOCK ? 4 : 7, 1, 8'h33);
    vecs[13] = mk(1'b1, 8'h34, 1'b1, 1'b0, RELOCK ? 5 : 8, 1, 8'h34);

    model_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; cnt_clr = 1'b0;
    cyc(1'b1, 8'h42, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_last", int'(last_data), 0);
    chk("reset_good", int'(good_cnt), 0);
    chk("reset_err", int'(err_cnt), 0);
    chk("reset_seen", int'(timeout_seen), 0);
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);

    // Directed table: lock, wrap through 0xFF, then a sequence break
    for (int i = 0; i < 14; i++) begin
      cyc(vecs[i].v, vecs[i].d, 1'b0);
      chk($sformatf("vec%0d_locked", i), int'(locked), int'(vecs[i].lk));
      chk($sformatf("vec%0d_err_pulse", i), int'(err_pulse), int'(vecs[i].ep));
      chk($sformatf("vec%0d_good", i), int'(good_cnt), vecs[i].good);
      chk($sformatf("vec%0d_errc", i), int'(err_cnt), vecs[i].errc);
      chk($sformatf("vec%0d_last", i), int'(last_data), int'(vecs[i].last));
    end

    // Watchdog expiry while locked
    np = 0;
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      np += int'(timeout_pulse);
    end
    chk("to_early_pulses", np, 0);
    chk("to_early_locked", int'(locked), 1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("to_pulse", int'(timeout_pulse), 1);
    chk("to_seen", int'(timeout_seen), 1);
    chk("to_locked", int'(locked), 0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("to_pulse_single", int'(timeout_pulse), 0);
    cyc(1'b1, 8'h55, 1'b0);
    chk("to_restart_err_pulse", int'(err_pulse), 0);
    chk("to_restart_errc", int'(err_cnt), 1);

    // Byte on the exact expiry cycle keeps the link
    cyc(1'b1, 8'h56, 1'b0);
    cyc(1'b1, 8'h57, 1'b0);
    cyc(1'b1, 8'h58, 1'b0);
    chk("relock_locked", int'(locked), 1);
    idle(int'(TIMEOUT) - 1);
    cyc(1'b1, 8'h59, 1'b0);
    chk("expiry_byte_no_pulse", int'(timeout_pulse), 0);
    chk("expiry_byte_locked", int'(locked), 1);
    chk("expiry_byte_good", int'(good_cnt), RELOCK ? 6 : 9);
    cyc(1'b1, 8'h5A, 1'b1);
    chk("clr_match_good", int'(good_cnt), 0);
    chk("clr_match_errc", int'(err_cnt), 0);
    chk("clr_match_seen", int'(timeout_seen), 0);
    chk("clr_match_last", int'(last_data), 8'h5A);

    // Clear coincident with a timeout: pulse fires, sticky flag stays clear
    idle(int'(TIMEOUT) - 1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("clr_to_pulse", int'(timeout_pulse), 1);
    chk("clr_to_seen", int'(timeout_seen), 0);
    chk("clr_to_locked", int'(locked), 0);

    // err_cnt saturation
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(i), 1'b0);
    chk("sat_locked", int'(locked), 1);
    e = 4;
    for (int i = 1; i <= 17; i++) begin
      m = (e + 16) % 256;
      cyc(1'b1, 8'(m), 1'b0);
      chk($sformatf("sat%0d_err_pulse", i), int'(err_pulse), 1);
      chk($sformatf("sat%0d_errc", i), int'(err_cnt), (i > CMAX) ? CMAX : i);
      for (int k = 1; k <= 3; k++) cyc(1'b1, 8'((m + k) % 256), 1'b0);
      e = (m + 4) % 256;
    end
    chk("sat_final_errc", int'(err_cnt), 15);

    // Reset mid-stream, then a slow acquisition
    rst_n = 1'b0;
    cyc(1'b1, 8'h99, 1'b0);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_errc", int'(err_cnt), 0);
    chk("midrst_last", int'(last_data), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(32);
      b = 8'h10 + 8'(i);
      cyc(1'b1, b, 1'b0);
      chk($sformatf("slow%0d_locked", i), int'(locked), (i == 3) ? 1 : 0);
    end
    chk("slow_good", int'(good_cnt), 0);
    chk("slow_errc", int'(err_cnt), 0);

    // Randomized traffic against the model
    ge = 0;
    while (ge < 4000) begin
      if ($urandom_range(0, 199) == 0) begin
        m = int'(TIMEOUT) - 2 + int'($urandom_range(0, 3));
        idle(m);
        ge += m;
      end else begin
        if ($urandom_range(0, 9) == 0) b = 8'($urandom_range(0, 255));
        else                           b = m_exp;
        cyc(($urandom_range(0, 99) < 40), b, ($urandom_range(0, 63) == 0));
        ge++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_check.md
Name: uart_rx_check

Overview:
- Receive-side counterpart of the UART test-pattern generator.
- Consumes bytes from the UART receiver and checks that they form a modulo-256 incrementing sequence (0x00, 0x01, …, 0xFF, 0x00, …).
- Reports lock status, sequence errors, link timeout and running statistics.
- Sits directly after uart_rx, in place of the loopback sink, and drives status LEDs/debug registers.

Parameters:
- TIMEOUT, 100000: cycles without rx_valid before link is declared lost (2× generator period of 50000).
- LOCK_CNT, 4: consecutive in-sequence bytes (including the first) required to enter LOCK; legal range 1..255.
- CNT_W, 16: width of good_cnt and err_cnt.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rx_data  in  8  received byte, valid only when rx_valid=1
- rx_valid  in  1  single-cycle strobe, one per received byte
- cnt_clr  in  1  synchronous clear of good_cnt, err_cnt and timeout_seen
- locked  out  1  high while FSM is in LOCK
- err_pulse  out  1  one-cycle pulse per sequence error detected in LOCK
- timeout_pulse  out  1  one-cycle pulse when the watchdog expires
- timeout_seen  out  1  sticky timeout flag
- last_data  out  8  last accepted rx_data
- good_cnt  out  CNT_W  in-sequence bytes accepted while in LOCK, saturating
- err_cnt  out  CNT_W  sequence errors in LOCK, saturating

Behaviour:
- Interface: reset rst_n, synchronous, active-low; clock clk.
- Reset values: all outputs 0; FSM in HUNT; expected byte exp=0; run=0; watchdog=0.
- All outputs are registered. Effects of an rx_valid sampled at edge N are visible after edge N, so status is valid in the following cycle.
- Match rule: rx_data == exp. exp is always loaded as rx_data+1 truncated to 8 bits, so 0xFF followed by 0x00 is a match.
- FSM states: HUNT, ACQ, LOCK.
  - HUNT, on rx_valid: exp<=rx_data+1, run<=1. Go to LOCK if LOCK_CNT==1, else ACQ. No errors are counted.
  - ACQ, on rx_valid with match: run<=run+1; go to LOCK when run+1==LOCK_CNT.
  - ACQ, on rx_valid with mismatch: run<=1, stay in ACQ, no err_pulse.
  - ACQ, any accepted byte: exp<=rx_data+1.
  - LOCK, on match: good_cnt+1, saturating at all-ones.
  - LOCK, on mismatch: err_pulse=1 for one cycle; err_cnt+1, saturating. Next state depends on the optional feature.
  - LOCK, any accepted byte: exp<=rx_data+1.
  - The byte that completes acquisition is not counted in good_cnt.
- last_data <= rx_data on every rx_valid, in any state.
- Watchdog:
  - Cleared to 0 on rx_valid and while in HUNT; increments otherwise.
  - Reaching TIMEOUT-1 in ACQ or LOCK causes timeout_pulse=1 for one cycle, timeout_seen<=1, FSM->HUNT, run<=0, watchdog<=0.
- Simultaneous events:
  - rx_valid in the same cycle the watchdog would expire: the byte is processed and no timeout occurs.
  - cnt_clr with an increment or timeout: clear wins. Counters are 0 and timeout_seen=0 next cycle. err_pulse and timeout_pulse still fire.
  - cnt_clr does not affect FSM, exp or last_data.
- Reset mid-stream: FSM returns to HUNT immediately and all statistics are lost. Reacquisition starts with the next byte.
- rx_data is ignored when rx_valid=0.

Optional Feature:
- Macro: UART_RX_CHECK_RELOCK_EN.
- Defined: a mismatch in LOCK moves the FSM to ACQ with run<=1, and locked drops the next cycle. LOCK_CNT further consecutive matches, counting the mismatching byte as the first, are needed to relock.
- Undefined: a mismatch in LOCK resyncs exp to rx_data+1 and stays in LOCK; locked remains 1.
- err_pulse and err_cnt behave identically in both cases.

Test Plan:
- Reset, then bytes 0x10,0x11,0x12,0x13 at 50000-cycle spacing -> locked=1 the cycle after 0x13; good_cnt=0, err_cnt=0.
- After lock, send 0xFE,0xFF,0x00,0x01 continuing the sequence -> no err_pulse, good_cnt increments to 4, last_data=0x01.
- Locked at exp=0x21, send 0x30 then 0x31 -> one err_pulse, err_cnt=1. Undefined macro: locked stays 1 and 0x31 increments good_cnt. Defined macro: locked=0 until 0x30..0x33 are received.
- Locked, then no rx_valid for TIMEOUT cycles -> exactly one timeout_pulse, timeout_seen=1, locked=0. The next byte restarts acquisition with no error.
- rx_valid on the exact expiry cycle -> no timeout. Then pulse cnt_clr on the same cycle as a matching byte -> good_cnt=0, err_cnt=0, timeout_seen=0.
- Force err_cnt to all-ones with CNT_W=4 (16 errors), then one more mismatch -> err_pulse fires, err_cnt stays 0xF.
